// File: rtl/alu_pipe.sv
// Registered ADD/NAND/PASS(/SUB) ALU owning the C/Z flags and the conditional write-back decision.
// Latency: 1 cycle from accept to out_valid; full throughput while out_ready is held high.
// Backpressure: in_ready = ~out_valid | out_ready; result holds while out_valid & ~out_ready. Define ALU_SUB_EN to enable SUB on op 10.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    input  logic [1:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_write,
    output logic             carry,
    output logic             zero,
    output logic             pos,
    output logic             neg,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_IF_C   = 2'b01;
    localparam logic [1:0] COND_IF_Z   = 2'b10;
    localparam logic [1:0] COND_NEVER  = 2'b11;

    logic             accept;
    logic             cond_met;
    logic             is_nop;
    logic             do_write;
    logic [WIDTH-1:0] res;
    logic             c_nxt;
    logic             z_nxt;
    logic [WIDTH:0]   sum;
`ifdef ALU_SUB_EN
    logic [WIDTH:0]   diff;
`endif

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign pos      = ~out[WIDTH-1];
    assign neg      = out[WIDTH-1];

    assign sum = {1'b0, in1} + {1'b0, in2};
`ifdef ALU_SUB_EN
    // Two's-complement subtract: carry out of the top bit means no borrow.
    assign diff = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
`endif

    always_comb begin
        cond_met = 1'b0;
        case (cond)
            COND_ALWAYS: cond_met = 1'b1;
            COND_IF_C:   cond_met = carry;
            COND_IF_Z:   cond_met = zero;
            COND_NEVER:  cond_met = 1'b0;
            default:     cond_met = 1'b0;
        endcase
    end

    always_comb begin
        res    = '0;
        c_nxt  = carry;
        z_nxt  = zero;
        is_nop = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                z_nxt = (sum[WIDTH-1:0] == '0);
            end
            OP_NAND: begin
                res   = ~(in1 & in2);
                z_nxt = ((in1 & in2) == {WIDTH{1'b1}});
            end
            OP_SUB: begin
`ifdef ALU_SUB_EN
                res   = diff[WIDTH-1:0];
                c_nxt = diff[WIDTH];
                z_nxt = (diff[WIDTH-1:0] == '0);
`else
                is_nop = 1'b1;
`endif
            end
            OP_PASS: res = in2;
            default: res = '0;
        endcase
    end

    // A NOP still occupies a handshake slot but never writes back or touches flags.
    assign do_write = cond_met & ~is_nop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_write <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (accept) begin
                out       <= res;
                out_write <= do_write;
                out_valid <= 1'b1;
                if (do_write) begin
                    carry    <= c_nxt;
                    zero     <= z_nxt;
                    wr_count <= wr_count + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_alu_pipe;

    localparam logic [1:0] ADD = 2'b00, NAND = 2'b01, SUB = 2'b10, PASS = 2'b11;
    localparam logic [1:0] C_ALW = 2'b00, C_IFC = 2'b01, C_IFZ = 2'b10, C_NEV = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1, in2;
    logic [1:0]  op, cond;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        out_write;
    logic        carry, zero, pos, neg;
    logic [3:0]  wr_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_valid;
    logic [15:0] m_out;
    logic        m_w;
    logic        m_c, m_z;
    logic [3:0]  m_cnt;
    logic        exp_rdy, got_rdy;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .cond(cond),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_write(out_write),
        .carry(carry), .zero(zero), .pos(pos), .neg(neg),
        .wr_count(wr_count)
    );

    task automatic model_reset();
        m_valid = 1'b0; m_out = '0; m_w = 1'b0; m_c = 1'b0; m_z = 1'b0; m_cnt = '0;
    endtask

    task automatic model_exec(input logic [1:0] o, input logic [1:0] cd, input logic [15:0] a, input logic [15:0] b);
        int   s;
        logic met, nc, nz, w;
        logic [15:0] r;
        met = (cd == C_ALW) ? 1'b1 : (cd == C_IFC) ? m_c : (cd == C_IFZ) ? m_z : 1'b0;
        nc = m_c; nz = m_z; w = met; r = '0;
        case (o)
            ADD: begin
                s  = int'(a) + int'(b);
                r  = s[15:0];
                nc = (s > 65535);
                nz = (r == 0);
            end
            NAND: begin
                r  = ~(a & b);
                nz = (r == 0);
            end
            SUB: begin
`ifdef ALU_SUB_EN
                r  = a - b;
                nc = (a >= b);
                nz = (a == b);
`else
                r = '0;
                w = 1'b0;
`endif
            end
            default: r = b;
        endcase
        if (w) begin
            m_c = nc; m_z = nz; m_cnt = m_cnt + 4'd1;
        end
        m_out = r; m_w = w;
    endtask

    // Drive one cycle of inputs, advance the model, and land 1ns after the edge.
    task automatic step(input logic v, input logic rdy, input logic [1:0] o, input logic [1:0] cd,
                        input logic [15:0] a, input logic [15:0] b);
        in_valid = v; out_ready = rdy; op = o; cond = cd; in1 = a; in2 = b;
        #1;
        got_rdy = in_ready;
        exp_rdy = ~m_valid | rdy;
        if (v && exp_rdy) begin
            model_exec(o, cd, a, b);
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; op = ADD; cond = C_ALW; in1 = 16'hFFFF; in2 = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out !== 16'h0000) begin bad++; $display("FAIL rst_out got=%h exp=0000", out); end
        total++; if ({out_write, carry, zero} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {out_write, carry, zero}); end
        total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
        in_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        step(1, 1, ADD, C_ALW, 16'hFFFF, 16'h0001);
        total++; if ({out_valid, out, out_write, carry, zero} !== {1'b1, 16'h0000, 3'b111})
            begin bad++; $display("FAIL add_wrap got v=%b out=%h w=%b c=%b z=%b exp v=1 out=0000 w=1 c=1 z=1", out_valid, out, out_write, carry, zero); end
        step(1, 1, ADD, C_IFC, 16'h0003, 16'h0004);
        total++; if ({out, out_write, carry, zero} !== {16'h0007, 3'b100})
            begin bad++; $display("FAIL add_ifc_taken got out=%h w=%b c=%b z=%b exp out=0007 w=1 c=0 z=0", out, out_write, carry, zero); end
        step(1, 1, ADD, C_IFC, 16'h0003, 16'h0004);
        total++; if ({out, out_write, carry, zero} !== {16'h0007, 3'b000})
            begin bad++; $display("FAIL add_ifc_skip got out=%h w=%b c=%b z=%b exp out=0007 w=0 c=0 z=0", out, out_write, carry, zero); end
        total++; if (wr_count !== 4'd2) begin bad++; $display("FAIL skip_wr_count got=%0d exp=2", wr_count); end
        step(1, 1, ADD, C_ALW, 16'hFFFF, 16'h0001);
        step(1, 1, NAND, C_ALW, 16'hFFFF, 16'hFFFF);
        total++; if ({out, out_write, carry, zero} !== {16'h0000, 3'b111})
            begin bad++; $display("FAIL nand got out=%h w=%b c=%b z=%b exp out=0000 w=1 c=1 z=1", out, out_write, carry, zero); end
        step(1, 1, PASS, C_IFZ, 16'h0000, 16'h1234);
        total++; if ({out, out_write, carry, zero, pos, neg} !== {16'h1234, 5'b11110})
            begin bad++; $display("FAIL pass_ifz got out=%h w=%b c=%b z=%b exp out=1234 w=1 c=1 z=1", out, out_write, carry, zero); end
        step(1, 1, ADD, C_NEV, 16'h0001, 16'h0001);
        total++; if ({out, out_write, carry, zero, wr_count} !== {16'h0002, 3'b011, 4'd5})
            begin bad++; $display("FAIL never got out=%h w=%b c=%b z=%b cnt=%0d exp out=0002 w=0 c=1 z=1 cnt=5", out, out_write, carry, zero, wr_count); end
    endtask

    task automatic test_sub();
        step(1, 1, SUB, C_ALW, 16'h0005, 16'h0007);
`ifdef ALU_SUB_EN
        total++; if ({out, out_write, carry, zero, neg} !== {16'hFFFE, 4'b1001})
            begin bad++; $display("FAIL sub got out=%h w=%b c=%b z=%b n=%b exp out=fffe w=1 c=0 z=0 n=1", out, out_write, carry, zero, neg); end
`else
        total++; if ({out_valid, out, out_write, carry, zero, wr_count} !== {1'b1, 16'h0000, 3'b011, 4'd5})
            begin bad++; $display("FAIL sub_nop got v=%b out=%h w=%b c=%b z=%b cnt=%0d exp v=1 out=0000 w=0 c=1 z=1 cnt=5", out_valid, out, out_write, carry, zero, wr_count); end
`endif
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        step(0, 1, ADD, C_ALW, 16'h0, 16'h0);
        step(1, 0, ADD, C_ALW, 16'h0010, 16'h0020);
        held = m_out;
        total++; if ({out_valid, out, in_ready} !== {1'b1, 16'h0030, 1'b0})
            begin bad++; $display("FAIL bp_first got v=%b out=%h rdy=%b exp v=1 out=0030 rdy=0", out_valid, out, in_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, PASS, C_ALW, 16'h0, 16'h0BEE);
            total++; if ({got_rdy, out_valid, out} !== {1'b0, 1'b1, held})
                begin bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b out=%h exp rdy=0 v=1 out=%h", i, got_rdy, out_valid, out, held); end
        end
        step(1, 1, PASS, C_ALW, 16'h0, 16'h0BEE);
        total++; if ({got_rdy, out_valid, out} !== {1'b1, 1'b1, 16'h0BEE})
            begin bad++; $display("FAIL bp_release got rdy=%b v=%b out=%h exp rdy=1 v=1 out=0bee", got_rdy, out_valid, out); end
        for (int i = 0; i < 6; i++) begin
            step(1, 1, ADD, C_ALW, 16'(i * 3), 16'(i + 100));
            total++; if ({got_rdy, out_valid, out, wr_count} !== {exp_rdy, 1'b1, m_out, m_cnt})
                begin bad++; $display("FAIL bp_stream%0d got rdy=%b out=%h cnt=%0d exp rdy=%b out=%h cnt=%0d", i, got_rdy, out, wr_count, exp_rdy, m_out, m_cnt); end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            if ($urandom_range(0, 5) == 0) b = 16'h0001;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 2'($urandom), 2'($urandom_range(0, 3) == 0 ? 3 : $urandom_range(0, 2)), a, b);
            total++;
            if ({got_rdy, out_valid, out, out_write, carry, zero, pos, neg, wr_count} !==
                {exp_rdy, m_valid, m_out, m_w, m_c, m_z, ~m_out[15], m_out[15], m_cnt})
                begin bad++; $display("FAIL rand%0d got rdy=%b v=%b out=%h w=%b c=%b z=%b cnt=%0d exp rdy=%b v=%b out=%h w=%b c=%b z=%b cnt=%0d",
                    i, got_rdy, out_valid, out, out_write, carry, zero, wr_count, exp_rdy, m_valid, m_out, m_w, m_c, m_z, m_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, ADD, C_ALW, 16'h0, 16'h0);
        step(1, 0, ADD, C_ALW, 16'hFFFF, 16'h0001);
        total++; if ({out_valid, carry} !== 2'b11) begin bad++; $display("FAIL pre_rst got v=%b c=%b exp v=1 c=1", out_valid, carry); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        total++; if ({out_valid, carry, zero, wr_count} !== 7'd0)
            begin bad++; $display("FAIL mid_rst got v=%b c=%b z=%b cnt=%0d exp all 0", out_valid, carry, zero, wr_count); end
        reset_n = 1'b1;
        step(1, 1, ADD, C_IFC, 16'h0001, 16'h0002);
        total++; if ({out_valid, out, out_write, wr_count} !== {1'b1, 16'h0003, 1'b0, 4'd0})
            begin bad++; $display("FAIL post_rst got v=%b out=%h w=%b cnt=%0d exp v=1 out=0003 w=0 cnt=0", out_valid, out, out_write, wr_count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sub();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
